// File: rtl/uart_tx_arbiter_if.sv
// Bundles the producer valid/ready bus and the uart_tx transmit/busy link.
// slave is the arbiter's view; master is the surrounding producers plus uart_tx.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_transmit;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_transmit, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_transmit, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte producers, with
// message locking via req_last and a START watchdog on the transmit/busy handshake.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned START_TIMEOUT = 65535,
    localparam int unsigned GrantW       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus,
    output logic [GrantW-1:0]   grant_id,
    output logic                active,
    output logic                timeout_err
);
    localparam int unsigned CntW = $clog2(START_TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StSend,
        StHold
    } state_e;

    state_e              state_q, state_d;
    logic [GrantW-1:0]   rr_q, rr_d;
    logic [GrantW-1:0]   grant_q, grant_d;
    logic                lock_q, lock_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                timeout_q, timeout_d;

    logic [DATA_W-1:0]   req_bytes [NUM_REQ];
    logic                win_found;
    logic [GrantW-1:0]   win_id;
    logic [GrantW-1:0]   idx;
    logic [NUM_REQ-1:0]  ready;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    function automatic logic [GrantW-1:0] next_id(input logic [GrantW-1:0] id);
        return (id == GrantW'(NUM_REQ - 1)) ? '0 : id + GrantW'(1);
    endfunction

    // First asserted valid at or after the RR pointer, wrapping past NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            if (32'(rr_q) + off >= NUM_REQ) begin
                idx = GrantW'(32'(rr_q) + off - NUM_REQ);
            end else begin
                idx = GrantW'(32'(rr_q) + off);
            end
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        ready = '0;
        case (state_q)
            StIdle:  if (win_found) ready[win_id] = 1'b1;
            StHold:  ready[grant_q] = 1'b1;
            default: ready = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                // A winner always has valid high, so ready implies a transfer here.
                if (win_found) begin
                    data_d  = req_bytes[win_id];
                    grant_d = win_id;
                    lock_d  = ~bus.req_last[win_id];
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bus.tx_busy) begin
                    state_d = StSend;
                end else if (cnt_q == CntW'(START_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    lock_d    = 1'b0;
                    rr_d      = next_id(grant_q);
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    if (lock_q) begin
                        state_d = StHold;
                    end else begin
                        rr_d    = next_id(grant_q);
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                if (bus.req_valid[grant_q]) begin
                    data_d  = req_bytes[grant_q];
                    lock_d  = ~bus.req_last[grant_q];
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_q      <= '0;
            grant_q   <= '0;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.tx_transmit = (state_q == StStart);
    assign bus.tx_data     = data_q;
    assign grant_id        = grant_q;
    assign active          = (state_q != StIdle);
    assign timeout_err     = timeout_q;

endmodule
